qspi_rom_reader: RTL and testbench

QSPI_ROM_READER -- requirements
Module: qspi_rom_reader

---
 rtl/qspi_pkg.sv | 45 ++++
 rtl/qspi_bit_timer.sv | 45 ++++
 rtl/qspi_rom_reader.sv | 161 ++++++++++++++++
 tb/tb_qspi_rom_reader.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/qspi_pkg.sv
// Shared types and constants for the quad-I/O fast-read (0xEB) ROM reader.
package qspi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_MODE,
        ST_DUMMY,
        ST_DATA,
        ST_DESEL
    } state_e;

    localparam int CNT_W = 8;

    localparam logic [7:0]       CMD_OPCODE = 8'hEB;
    localparam logic [3:0]       MODE_NIB   = 4'h0;

    localparam logic [CNT_W-1:0] CMD_SCK    = CNT_W'(8);
    localparam logic [CNT_W-1:0] ADDR_SCK   = CNT_W'(6);
    localparam logic [CNT_W-1:0] MODE_SCK   = CNT_W'(2);
    localparam logic [CNT_W-1:0] DATA_SCK   = CNT_W'(2);
    localparam logic [CNT_W-1:0] DESEL_SCK  = CNT_W'(1);

    localparam logic [3:0]       OE_CMD     = 4'b1101;
    localparam logic [3:0]       OE_ADDR    = 4'b1111;
    localparam logic [3:0]       OE_MODE    = 4'b1111;
    localparam logic [3:0]       OE_IN      = 4'b0000;

    // DESEL reuses the bit timer: one 2-clk "period" with SCK gated off.
    function automatic logic [CNT_W-1:0] sck_len(input state_e s, input logic [CNT_W-1:0] dummy);
        logic [CNT_W-1:0] len;
        len = DESEL_SCK;
        case (s)
            ST_CMD:   len = CMD_SCK;
            ST_ADDR:  len = ADDR_SCK;
            ST_MODE:  len = MODE_SCK;
            ST_DUMMY: len = dummy;
            ST_DATA:  len = DATA_SCK;
            default:  len = DESEL_SCK;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/qspi_bit_timer.sv
// SCK phase generator and per-state SCK counter; tc_o strobes on the edge that ends the last SCK.
module qspi_bit_timer
    import qspi_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             run_i,
    input  logic             clr_i,
    input  logic [CNT_W-1:0] len_i,
    output logic             phase_o,
    output logic             sck_end_o,
    output logic             tc_o
);

    logic             phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign phase_o   = phase_q;
    assign sck_end_o = run_i & phase_q;
    assign tc_o      = sck_end_o & (cnt_q == len_i - CNT_W'(1));

    // A state change restarts the count at the low phase of the first SCK.
    always_comb begin
        phase_d = 1'b0;
        cnt_d   = '0;
        if (run_i && !clr_i) begin
            phase_d = ~phase_q;
            cnt_d   = cnt_q;
            if (phase_q) begin
                cnt_d = tc_o ? '0 : cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            phase_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/qspi_rom_reader.sv
// Single-byte quad-I/O fast-read (0xEB) reader for a serial ROM, SCK = clk/2.
// Define QSPI_ROM_READER_BURST_EN to chain sequential reads without deselecting.
module qspi_rom_reader
    import qspi_pkg::*;
#(
    parameter int DUMMY_CLKS = 4,
    parameter int ADDR_W     = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic [ADDR_W-1:0] addr,
    output logic              ready,
    output logic              data_valid,
    output logic [7:0]        data,
    output logic              qspi_sck,
    output logic              qspi_ss_n,
    output logic [3:0]        qspi_io_out,
    output logic [3:0]        qspi_io_oe,
    input  logic [3:0]        qspi_io_in
);

    localparam logic [CNT_W-1:0] DUMMY_LEN = CNT_W'(DUMMY_CLKS);

    state_e           state_q, state_d;
    logic             run, clr, phase, sck_end, tc, accept, active;
    logic [CNT_W-1:0] len;
    logic [31:0]      sh_q, sh_d;
    logic [7:0]       din_q, din_d;
    logic [7:0]       data_q;
    logic             byte_done_q, data_valid_q;

    function automatic logic [23:0] addr_to_24(input logic [ADDR_W-1:0] a);
        logic [23:0] r;
        r = '0;
        for (int i = 0; i < ADDR_W && i < 24; i++) begin
            r[i] = a[i];
        end
        return r;
    endfunction

`ifdef QSPI_ROM_READER_BURST_EN
    logic [ADDR_W-1:0] addr_q;
    logic              burst_ok;
    assign burst_ok = data_valid_q && req && (addr == addr_q + ADDR_W'(1));
`endif

    assign run = (state_q != ST_IDLE);
    assign clr = (state_d != state_q);
    assign len = sck_len(state_q, DUMMY_LEN);

    qspi_bit_timer u_timer (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .run_i    (run),
        .clr_i    (clr),
        .len_i    (len),
        .phase_o  (phase),
        .sck_end_o(sck_end),
        .tc_o     (tc)
    );

    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ready = 1'b1;
                if (req) begin
                    accept  = 1'b1;
                    state_d = ST_CMD;
                end
            end
            ST_CMD:   if (tc) state_d = ST_ADDR;
            ST_ADDR:  if (tc) state_d = ST_MODE;
            ST_MODE:  if (tc) state_d = (DUMMY_CLKS == 0) ? ST_DATA : ST_DUMMY;
            ST_DUMMY: if (tc) state_d = ST_DATA;
            ST_DATA: begin
`ifdef QSPI_ROM_READER_BURST_EN
                // The flash keeps streaming after each byte; the first SCK of the
                // next byte runs speculatively and is dropped unless a sequential
                // request arrives in the data_valid cycle (others are discarded).
                ready = data_valid_q;
                if (data_valid_q && !burst_ok) state_d = ST_DESEL;
`else
                if (tc) state_d = ST_DESEL;
`endif
            end
            ST_DESEL: if (tc) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Opcode and address share one shifter: 1 bit/SCK in CMD, 1 nibble/SCK in ADDR.
    always_comb begin
        sh_d  = sh_q;
        din_d = din_q;
        if (accept) begin
            sh_d = {CMD_OPCODE, addr_to_24(addr)};
        end else if (sck_end && state_q == ST_CMD) begin
            sh_d = sh_q << 1;
        end else if (sck_end && state_q == ST_ADDR) begin
            sh_d = sh_q << 4;
        end
        if (sck_end && state_q == ST_DATA) begin
            din_d = {din_q[3:0], qspi_io_in};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            sh_q         <= '0;
            din_q        <= '0;
            data_q       <= '0;
            byte_done_q  <= 1'b0;
            data_valid_q <= 1'b0;
`ifdef QSPI_ROM_READER_BURST_EN
            addr_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            sh_q         <= sh_d;
            din_q        <= din_d;
            byte_done_q  <= tc && (state_q == ST_DATA);
            data_valid_q <= byte_done_q;
            if (byte_done_q) data_q <= din_q;
`ifdef QSPI_ROM_READER_BURST_EN
            if (accept || (state_q == ST_DATA && burst_ok)) addr_q <= addr;
`endif
        end
    end

    assign active     = (state_q != ST_IDLE) && (state_q != ST_DESEL);
    assign qspi_ss_n  = ~active;
    assign qspi_sck   = active & phase;
    assign data_valid = data_valid_q;
    assign data       = data_q;

    always_comb begin
        qspi_io_out = 4'h0;
        qspi_io_oe  = OE_IN;
        case (state_q)
            ST_CMD: begin
                qspi_io_oe  = OE_CMD;
                qspi_io_out = {2'b11, 1'b0, sh_q[31]};
            end
            ST_ADDR: begin
                qspi_io_oe  = OE_ADDR;
                qspi_io_out = sh_q[31:28];
            end
            ST_MODE: begin
                qspi_io_oe  = OE_MODE;
                qspi_io_out = MODE_NIB;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_qspi_rom_reader.sv
// Bench for qspi_rom_reader: behavioural flash model plus table-driven and corner-case reads.
module tb_qspi_rom_reader;

    localparam int DUMMY = 4;
`ifdef QSPI_ROM_READER_BURST_EN
    localparam int EXP_RISES = 23;
`else
    localparam int EXP_RISES = 22;
`endif
    localparam int EXP_LAT = 2 * (18 + DUMMY) + 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req;
    logic [23:0] addr;
    logic        ready;
    logic        data_valid;
    logic [7:0]  data;
    logic        qspi_sck;
    logic        qspi_ss_n;
    logic [3:0]  qspi_io_out;
    logic [3:0]  qspi_io_oe;
    logic [3:0]  qspi_io_in = 4'h0;

    int checks = 0;
    int errors = 0;

    qspi_rom_reader #(.DUMMY_CLKS(DUMMY), .ADDR_W(24)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .addr       (addr),
        .ready      (ready),
        .data_valid (data_valid),
        .data       (data),
        .qspi_sck   (qspi_sck),
        .qspi_ss_n  (qspi_ss_n),
        .qspi_io_out(qspi_io_out),
        .qspi_io_oe (qspi_io_oe),
        .qspi_io_in (qspi_io_in)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] flash_byte(input logic [23:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    // Flash model: decodes the bus on SCK rising edges, streams bytes from the decoded address.
    int          m_rises = 0;
    int          m_bad = 0;
    int          m_n = 0;
    logic [7:0]  m_cmd = 8'h00;
    logic [23:0] m_addr = 24'h0;
    logic [7:0]  m_b = 8'h00;

    always @(posedge qspi_sck or negedge qspi_ss_n) begin
        if (!qspi_sck) begin
            m_rises = 0;
            m_bad   = 0;
            m_cmd   = 8'h00;
            m_addr  = 24'h0;
        end else begin
            m_rises++;
            if (m_rises <= 8) begin
                m_cmd = {m_cmd[6:0], qspi_io_out[0]};
                if (qspi_io_oe !== 4'b1101 || qspi_io_out[3:2] !== 2'b11) m_bad++;
            end else if (m_rises <= 14) begin
                m_addr = {m_addr[19:0], qspi_io_out};
                if (qspi_io_oe !== 4'b1111) m_bad++;
            end else if (m_rises <= 16) begin
                if (qspi_io_oe !== 4'b1111 || qspi_io_out !== 4'h0) m_bad++;
            end else begin
                if (qspi_io_oe !== 4'b0000) m_bad++;
                if (m_rises > 16 + DUMMY) begin
                    m_n = m_rises - 17 - DUMMY;
                    m_b = flash_byte(m_addr + 24'(m_n / 2));
                    qspi_io_in = (m_n % 2 == 0) ? m_b[7:4] : m_b[3:0];
                end
            end
        end
    end

    int dv_total = 0;
    int ssn_falls = 0;
    always @(posedge clk) if (data_valid) dv_total++;
    always @(negedge qspi_ss_n) ssn_falls++;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    int         r_ndv, r_desel, r_ssn0, r_rdy_dv;
    int         r_lat[2];
    logic [7:0] r_dat[2];
`ifdef QSPI_ROM_READER_BURST_EN
    int         r_gap;
`endif

    // One read from IDLE; k counts negedges after the accepting posedge.
    task automatic do_read(input logic [23:0] a, input bit chain, input logic [23:0] chain_a);
        int k;
        bit done;
        bit pend;
        r_ndv = 0; r_desel = 0; r_ssn0 = 1; r_rdy_dv = 0;
        r_lat[0] = -1; r_lat[1] = -1; r_dat[0] = 8'h00; r_dat[1] = 8'h00;
`ifdef QSPI_ROM_READER_BURST_EN
        r_gap = 0;
`endif
        @(negedge clk); req = 1'b1; addr = a;
        @(negedge clk); req = 1'b0;
        k = 0; done = 1'b0; pend = 1'b0;
        while (!done && k < 120) begin
            if (pend) begin req = 1'b0; pend = 1'b0; end
            if (k == 0) r_ssn0 = int'(qspi_ss_n);
            if (qspi_ss_n && !ready) r_desel++;
`ifdef QSPI_ROM_READER_BURST_EN
            if (r_ndv == 1 && qspi_ss_n) r_gap++;
`endif
            if (data_valid) begin
                if (r_ndv < 2) begin r_dat[r_ndv] = data; r_lat[r_ndv] = k; end
                r_ndv++;
                if (r_ndv == 1 && chain) begin
                    req = 1'b1; addr = chain_a; pend = 1'b1; r_rdy_dv = int'(ready);
                end
            end
            if (ready && qspi_ss_n && k > 0 && !pend) done = 1'b1;
            else begin @(negedge clk); k++; end
        end
        check("read_completes", int'(done), 1);
    endtask

    typedef struct {
        logic [23:0] a;
        logic [7:0]  exp;
    } vec_t;

    vec_t vecs[6];
    int   d0, f0;

    initial begin
        req = 1'b0;
        addr = 24'h0;
        vecs[0] = '{24'h000123, 8'h79};
        vecs[1] = '{24'h000010, 8'h4A};
        vecs[2] = '{24'hFFFFFF, 8'hA5};
        vecs[3] = '{24'hABCDEF, 8'hB5};
        for (int i = 4; i < 6; i++) begin
            vecs[i].a   = 24'($urandom);
            vecs[i].exp = flash_byte(vecs[i].a);
        end

        #1 rst_n = 1'b0;
        #1;
        check("rst_ss_n", int'(qspi_ss_n), 1);
        check("rst_sck", int'(qspi_sck), 0);
        check("rst_oe", int'(qspi_io_oe), 0);
        check("rst_io_out", int'(qspi_io_out), 0);
        check("rst_data_valid", int'(data_valid), 0);
        check("rst_data", int'(data), 0);
        check("rst_ready", int'(ready), 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", int'(ready), 1);

        for (int i = 0; i < 6; i++) begin
            do_read(vecs[i].a, 1'b0, 24'h0);
            check("ss_n_low_after_accept", r_ssn0, 0);
            check("data", int'(r_dat[0]), int'(vecs[i].exp));
            check("dv_latency", r_lat[0], EXP_LAT);
            check("dv_count", r_ndv, 1);
            check("sck_rises", m_rises, EXP_RISES);
            check("cmd_opcode", int'(m_cmd), 32'hEB);
            check("addr_on_bus", int'(m_addr), int'(vecs[i].a));
            check("bus_oe_pattern", m_bad, 0);
            check("desel_clks", r_desel, 2);
        end

        do_read(24'hFFFFFF, 1'b1, 24'h000000);
        check("chain_first_byte", int'(r_dat[0]), 32'hA5);
`ifdef QSPI_ROM_READER_BURST_EN
        check("chain_dv_count", r_ndv, 2);
        check("chain_second_byte", int'(r_dat[1]), 32'h5A);
        check("chain_dv_spacing", r_lat[1] - r_lat[0], 4);
        check("chain_ss_n_gap", r_gap, 0);
        check("chain_ready_in_dv", r_rdy_dv, 1);
        check("chain_desel_clks", r_desel, 2);
`else
        f0 = ssn_falls;
        repeat (60) @(negedge clk);
        check("chain_dv_count", r_ndv, 1);
        check("chain_ready_in_dv", r_rdy_dv, 0);
        check("chain_desel_clks", r_desel, 2);
        check("chain_req_ignored", ssn_falls - f0, 0);
        check("chain_ready_after", int'(ready), 1);
`endif

        d0 = dv_total;
        @(negedge clk); req = 1'b1; addr = 24'h000123;
        @(negedge clk); req = 1'b0;
        repeat (20) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_ss_n", int'(qspi_ss_n), 1);
        check("midrst_oe", int'(qspi_io_oe), 0);
        check("midrst_sck", int'(qspi_sck), 0);
        check("midrst_data", int'(data), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        check("midrst_no_dv", dv_total - d0, 0);
        do_read(24'h000010, 1'b0, 24'h0);
        check("post_rst_data", int'(r_dat[0]), 32'h4A);
        check("post_rst_latency", r_lat[0], EXP_LAT);

        d0 = dv_total;
        f0 = ssn_falls;
        @(negedge clk); req = 1'b1; addr = 24'h000200;
        repeat (60) @(negedge clk);
        req = 1'b0;
        repeat (150) @(negedge clk);
        check("held_req_accepts", ssn_falls - f0, 2);
        check("held_req_dv", dv_total - d0, 2);
        check("held_req_idle", int'(ready), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
